c5_shift_pipe: RTL and testbench

- Two-stage pipelined execute slot around the combinational shifter `c5_shifter`.
- Stage 1 takes shift ops from decode with a valid/ready handshake, selects the shift amount (immediate shamt or variable rs[4:0]) and registers the operands.
- Stage 2 feeds the registered operands through `c5_shifter` and registers the result, tagged with its destination register, for writeback.
- Sustains one op per cycle. Back-pressure propagates from writeback to decode.

---
 rtl/c5_shift_pipe.sv | 145 ++++++++++++++
 tb/tb_c5_shift_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/c5_shift_pipe.sv
// c5_shift_pipe: two-stage shift execute slot, decode -> c5_shifter -> writeback. Macro C5_SHIFT_FLUSH_EN adds I_flush.
// Latency 2 cycles at one op/cycle; holds 2 ops, and O_in_ready drops when both stages are blocked by writeback.

module c5_shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [4:0]       amt_i,
  input  logic [1:0]       func_i,
  output logic [WIDTH-1:0] res_o
);
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  always_comb begin
    res_o = '0;
    case (func_i)
      SHIFT_SLL: res_o = val_i << amt_i;
      SHIFT_SRL: res_o = val_i >> amt_i;
      SHIFT_SRA: res_o = WIDTH'($signed(val_i) >>> amt_i);
      default:   res_o = '0;
    endcase
  end
endmodule

module c5_shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_in_valid,
  output logic               O_in_ready,
  input  logic [WIDTH-1:0]   I_rt,
  input  logic [WIDTH-1:0]   I_rs,
  input  logic [4:0]         I_shamt,
  input  logic               I_variable,
  input  logic [1:0]         I_shift_func,
  input  logic [RD_BITS-1:0] I_rd,
  output logic               O_valid,
  input  logic               I_out_ready,
  output logic [WIDTH-1:0]   O_result,
  output logic [RD_BITS-1:0] O_rd,
`ifdef C5_SHIFT_FLUSH_EN
  input  logic               I_flush,
`endif
  output logic               O_we
);
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [4:0]         amt_q, amt_d;
  logic [1:0]         func_q, func_d;
  logic [RD_BITS-1:0] rd_q, rd_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [RD_BITS-1:0] out_rd_q, out_rd_d;

  logic               s2_free, s1_adv, in_ready, in_xfer, out_xfer;
  logic [WIDTH-1:0]   shift_res;
  logic               unused_rs_hi;

  // Only the low five bits of rs form a shift amount.
  assign unused_rs_hi = ^I_rs[WIDTH-1:5];

  c5_shifter #(.WIDTH(WIDTH)) u_shifter (
    .val_i  (val_q),
    .amt_i  (amt_q),
    .func_i (func_q),
    .res_o  (shift_res)
  );

  always_comb begin
    s2_free  = !s2_valid_q || I_out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
`ifdef C5_SHIFT_FLUSH_EN
    in_ready = in_ready && !I_flush;
`endif
    in_xfer  = I_in_valid && in_ready;
    out_xfer = s2_valid_q && I_out_ready;

    s1_valid_d = s1_valid_q;
    val_d      = val_q;
    amt_d      = amt_q;
    func_d     = func_q;
    rd_d       = rd_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      val_d      = I_rt;
      amt_d      = I_variable ? I_rs[4:0] : I_shamt;
      func_d     = I_shift_func;
      rd_d       = I_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    out_rd_d   = out_rd_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      result_d   = shift_res;
      out_rd_d   = rd_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

`ifdef C5_SHIFT_FLUSH_EN
    // Flush drops both stages' valids; data registers are left as-is.
    if (I_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      s1_valid_q <= 1'b0;
      val_q      <= '0;
      amt_q      <= '0;
      func_q     <= '0;
      rd_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      out_rd_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      val_q      <= val_d;
      amt_q      <= amt_d;
      func_q     <= func_d;
      rd_q       <= rd_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign O_in_ready = in_ready;
  assign O_valid    = s2_valid_q;
  assign O_result   = result_q;
  assign O_rd       = out_rd_q;
  assign O_we       = s2_valid_q && (out_rd_q != '0);
endmodule

// File: tb/tb_c5_shift_pipe.sv
// Directed bench for c5_shift_pipe; inputs change and outputs are sampled 1ns after the rising edge.
module tb_c5_shift_pipe;
  localparam logic [1:0] F_SLL = 2'b00;
  localparam logic [1:0] F_SRL = 2'b10;
  localparam logic [1:0] F_SRA = 2'b11;
  localparam logic [1:0] F_BAD = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, variable, out_valid, out_ready, we;
  logic [31:0] rt, rs, result;
  logic [4:0]  shamt, rd, out_rd;
  logic [1:0]  func;
  logic        flush;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  c5_shift_pipe dut (
    .I_clk(clk), .I_reset(rst), .I_in_valid(in_valid), .O_in_ready(in_ready),
    .I_rt(rt), .I_rs(rs), .I_shamt(shamt), .I_variable(variable),
    .I_shift_func(func), .I_rd(rd), .O_valid(out_valid), .I_out_ready(out_ready),
    .O_result(result), .O_rd(out_rd),
`ifdef C5_SHIFT_FLUSH_EN
    .I_flush(flush),
`endif
    .O_we(we)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a_rt, input logic [31:0] a_rs,
                       input logic [4:0] a_sh, input logic a_var, input logic [1:0] a_f,
                       input logic [4:0] a_rd);
    in_valid = v; rt = a_rt; rs = a_rs; shamt = a_sh; variable = a_var; func = a_f; rd = a_rd;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, F_SLL, 5'd0);
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h want 00000000", result); end
    n_cmp++; if (out_rd !== 5'd0) begin n_bad++; $display("FAIL rst_rd: got %0d want 0", out_rd); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
    #5 rst = 1'b0;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sll;
    out_ready = 1'b1;
    drive(1'b1, 32'h1, 32'h0, 5'd31, 1'b0, F_SLL, 5'd3);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sll_latency1: got %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sll_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'h80000000) begin n_bad++; $display("FAIL sll_result: got %h want 80000000", result); end
    n_cmp++; if (out_rd !== 5'd3) begin n_bad++; $display("FAIL sll_rd: got %0d want 3", out_rd); end
    n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL sll_we: got %b want 1", we); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sll_drain: got %b want 0", out_valid); end
  endtask

  // Two ops on consecutive cycles: results appear on consecutive cycles.
  task automatic test_sra_srl;
    out_ready = 1'b1;
    drive(1'b1, 32'h80000000, 32'h0, 5'd4, 1'b0, F_SRA, 5'd4);
    tick;
    drive(1'b1, 32'h80000000, 32'h0, 5'd4, 1'b0, F_SRL, 5'd5);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'hF8000000) begin n_bad++; $display("FAIL sra_result: got %h want f8000000", result); end
    n_cmp++; if (out_rd !== 5'd4) begin n_bad++; $display("FAIL sra_rd: got %0d want 4", out_rd); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL srl_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'h08000000) begin n_bad++; $display("FAIL srl_result: got %h want 08000000", result); end
    n_cmp++; if (out_rd !== 5'd5) begin n_bad++; $display("FAIL srl_rd: got %0d want 5", out_rd); end
    tick;
  endtask

  task automatic test_variable;
    out_ready = 1'b1;
    drive(1'b1, 32'h3, 32'h00000025, 5'd0, 1'b1, F_SLL, 5'd7);
    tick;
    drive(1'b1, 32'h3, 32'h00000025, 5'd0, 1'b1, F_SLL, 5'd0);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'h00000060) begin n_bad++; $display("FAIL var_result: got %h want 00000060", result); end
    n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL var_we: got %b want 1", we); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rd0_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'h00000060) begin n_bad++; $display("FAIL rd0_result: got %h want 00000060", result); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rd0_we: got %b want 0", we); end
    tick;
  endtask

  // Amount 0 passthrough, positive SRA, unused func encoding.
  task automatic test_func_edges;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, F_SRA, 5'd1);
    tick;
    drive(1'b1, 32'h40000000, 32'h0, 5'd4, 1'b0, F_SRA, 5'd2);
    tick;
    drive(1'b1, 32'hFFFFFFFF, 32'h0, 5'd3, 1'b0, F_BAD, 5'd6);
    n_cmp++; if (result !== 32'hDEADBEEF) begin n_bad++; $display("FAIL amt0_result: got %h want deadbeef", result); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'h04000000) begin n_bad++; $display("FAIL sra_pos_result: got %h want 04000000", result); end
    tick;
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL badfunc_result: got %h want 00000000", result); end
    n_cmp++; if (out_rd !== 5'd6) begin n_bad++; $display("FAIL badfunc_rd: got %0d want 6", out_rd); end
    tick;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'h0, 5'd0, 1'b0, F_SLL, 5'd10);
    tick;
    drive(1'b1, 32'd2, 32'h0, 5'd1, 1'b0, F_SLL, 5'd11);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept2: got %b want 1", in_ready); end
    tick;
    drive(1'b1, 32'd3, 32'h0, 5'd2, 1'b0, F_SLL, 5'd12);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_refuse3: got %b want 0", in_ready); end
    n_cmp++; if (result !== 32'd1) begin n_bad++; $display("FAIL bp_first: got %h want 00000001", result); end
    tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_still_full: got %b want 0", in_ready); end
    n_cmp++; if (result !== 32'd1 || out_rd !== 5'd10) begin n_bad++; $display("FAIL bp_hold: got %h/%0d want 00000001/10", result, out_rd); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick;
    drive(1'b1, 32'd4, 32'h0, 5'd3, 1'b0, F_SLL, 5'd13);
    n_cmp++; if (result !== 32'd4 || out_rd !== 5'd11) begin n_bad++; $display("FAIL bp_out2: got %h/%0d want 00000004/11", result, out_rd); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'd12 || out_rd !== 5'd12) begin n_bad++; $display("FAIL bp_out3: got %h/%0d want 0000000c/12", result, out_rd); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd32 || out_rd !== 5'd13) begin n_bad++; $display("FAIL bp_out4: got %b/%h/%0d want 1/00000020/13", out_valid, result, out_rd); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 32'h5, 32'h0, 5'd1, 1'b0, F_SLL, 5'd8);
    tick;
    drive(1'b1, 32'h6, 32'h0, 5'd1, 1'b0, F_SLL, 5'd9);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL mid_result: got %h want 00000000", result); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL mid_we: got %b want 0", we); end
    #10 rst = 1'b0;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got %b want 0", out_valid); end
  endtask

`ifdef C5_SHIFT_FLUSH_EN
  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h0, 5'd1, 1'b0, F_SLL, 5'd1);
    tick;
    drive(1'b1, 32'h1, 32'h0, 5'd2, 1'b0, F_SLL, 5'd2);
    tick;
    drive(1'b1, 32'h1, 32'h0, 5'd3, 1'b0, F_SLL, 5'd3);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset;
    test_sll;
    test_sra_srl;
    test_variable;
    test_func_edges;
    test_back_to_back;
    test_reset_mid;
`ifdef C5_SHIFT_FLUSH_EN
    test_flush;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
